// File: rtl/s2p_align_lanes.sv
// Multi-lane serial-to-parallel deserializer with word alignment.
// Lane 0 is searched for SYNC_WORD. Once lock is reached, every lane
// presents one WIDTH-bit word per word boundary with a single-cycle valid.
module s2p_align_lanes #(
  parameter int unsigned     LANES     = 4,
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD = 8'hBC,
  parameter int unsigned     LOCK_CNT  = 2
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   ENB,
  input  logic [LANES-1:0]       s_in,
  input  logic                   realign,
  output logic [LANES*WIDTH-1:0] p_out,
  output logic                   p_valid,
  output logic                   is_sync,
  output logic                   locked
);

  localparam int unsigned CntW   = $clog2(WIDTH);
  localparam int unsigned FillW  = $clog2(WIDTH + 1);
  localparam int unsigned MatchW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {StHunt, StCheck, StLocked} state_e;

  state_e                         state_q;
  logic [LANES-1:0][WIDTH-1:0]    sh_q;
  logic [LANES-1:0][WIDTH-1:0]    sh_nxt;
  logic [CntW-1:0]                bit_cnt_q;
  logic [FillW-1:0]               fill_q;
  logic [MatchW-1:0]              match_q;
  logic [LANES*WIDTH-1:0]         p_out_q;
  logic                           p_valid_q;
  logic                           is_sync_q;
  logic                           lane0_hit;
  logic                           word_end;
  logic                           fill_ok;

  // Post-shift view of every lane; first-received bit ends up as the MSB.
  always_comb begin
    for (int k = 0; k < int'(LANES); k++) begin
      sh_nxt[k] = {sh_q[k][WIDTH-2:0], s_in[k]};
    end
  end

  assign lane0_hit = (sh_nxt[0] == SYNC_WORD);
  assign word_end  = (bit_cnt_q == CntW'(WIDTH - 1));
  // The current shift will bring the fill to at least WIDTH bits.
  assign fill_ok   = (fill_q >= FillW'(WIDTH - 1));

  // Alignment FSM, shift registers, counters and registered outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= StHunt;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      p_out_q   <= '0;
      p_valid_q <= 1'b0;
      is_sync_q <= 1'b0;
    end else begin
      p_valid_q <= 1'b0;
      is_sync_q <= 1'b0;
      if (realign) begin
        // p_out deliberately keeps its last word.
        state_q   <= StHunt;
        sh_q      <= '0;
        bit_cnt_q <= '0;
        fill_q    <= '0;
        match_q   <= '0;
      end else if (ENB) begin
        sh_q <= sh_nxt;
        unique case (state_q)
          StHunt: begin
            if (fill_q != FillW'(WIDTH)) fill_q <= fill_q + 1'b1;
            if (fill_ok && lane0_hit) begin
              bit_cnt_q <= '0;
              if (LOCK_CNT == 1) begin
                state_q <= StLocked;
              end else begin
                state_q <= StCheck;
                match_q <= MatchW'(1);
              end
            end
          end
          StCheck: begin
            bit_cnt_q <= word_end ? '0 : bit_cnt_q + 1'b1;
            if (word_end) begin
              if (lane0_hit) begin
                match_q <= match_q + 1'b1;
                if (MatchW'(match_q + 1'b1) == MatchW'(LOCK_CNT)) state_q <= StLocked;
              end else begin
                // Window is already full, so a hit on the very next bit counts.
                state_q <= StHunt;
                match_q <= '0;
                fill_q  <= FillW'(WIDTH);
              end
            end
          end
          StLocked: begin
            bit_cnt_q <= word_end ? '0 : bit_cnt_q + 1'b1;
            if (word_end) begin
              p_out_q   <= sh_nxt;
              p_valid_q <= 1'b1;
              is_sync_q <= lane0_hit;
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

  assign p_out   = p_out_q;
  assign p_valid = p_valid_q;
  assign is_sync = is_sync_q;
  assign locked  = (state_q == StLocked);

endmodule
